// File: rtl/sh_rx_pkg.sv
// rtl/sh_rx_pkg.sv - shared state encoding, CRC polynomial and defaults for the sh_rx receive path
package sh_rx_pkg;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARMED    = 3'd1;
    localparam logic [2:0] ST_DELAY    = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_COMPLETE = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    localparam int DEF_PACKET_BITS    = 64;
    localparam int DEF_TIMEOUT_CYCLES = 15000;
endpackage

// File: rtl/sh_rx_crc8.sv
// rtl/sh_rx_crc8.sv - serial CRC-8, one bit per enable, MSB-first shift
module sh_rx_crc8
    import sh_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);
    logic fb;

    assign fb = crc[7] ^ bit_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end
endmodule

// File: rtl/sh_rx_deser.sv
// rtl/sh_rx_deser.sv - strobe-driven comparator deserializer with one-deep valid/ready output register
// Optional CRC-8 check of the trailing byte (pkt_crc_ok) when SH_RX_CRC_EN is defined.
module sh_rx_deser
    import sh_rx_pkg::*;
#(
    parameter int PACKET_BITS    = DEF_PACKET_BITS,
    parameter int SAMPLE_DELAY   = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_mode,
    input  logic                   sh_en,
    input  logic                   fsm_rst,
    input  logic                   cmp_in,
    output logic [PACKET_BITS-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   overrun,
    output logic                   timeout_err
`ifdef SH_RX_CRC_EN
    ,
    output logic                   pkt_crc_ok
`endif
);
    localparam int CW = $clog2(PACKET_BITS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0]    DLY    = 4'(SAMPLE_DELAY);
    localparam logic [CW-1:0] LAST   = CW'(PACKET_BITS);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

    logic [2:0]             state, next_state, after_sample;
    logic [1:0]             cmp_sync;
    logic                   cmp_s;
    logic [PACKET_BITS-1:0] sr, sr_next;
    logic [CW-1:0]          bit_cnt;
    logic [3:0]             dly_cnt;
    logic [WW-1:0]          wdog;
    logic                   strobe_ok, sample_now, clr_sr, load;

    assign cmp_s      = cmp_sync[1];
    assign strobe_ok  = (state == ST_ARMED || state == ST_SHIFT) && sh_en && rx_mode && !fsm_rst;
    // With zero delay the strobe cycle itself is the sample point and DELAY is never entered.
    assign sample_now = rx_mode && !fsm_rst &&
                        ((state == ST_DELAY && dly_cnt == DLY) || (strobe_ok && DLY == 4'd0));
    assign sr_next    = MSB_FIRST ? {sr[PACKET_BITS-2:0], cmp_s} : {cmp_s, sr[PACKET_BITS-1:1]};
    assign after_sample = (bit_cnt + CW'(1) == LAST) ? ST_COMPLETE : ST_SHIFT;
    assign clr_sr     = (next_state == ST_ARMED) || (next_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!rx_mode) begin
            next_state = ST_IDLE;
        end else if (fsm_rst && state != ST_COMPLETE) begin
            next_state = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED, ST_SHIFT: begin
                    if (sh_en) begin
                        next_state = (DLY == 4'd0) ? after_sample : ST_DELAY;
                    end else if (state == ST_SHIFT && wdog == WD_MAX) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_DELAY:    if (dly_cnt == DLY) next_state = after_sample;
                ST_COMPLETE: next_state = fsm_rst ? ST_ARMED : ST_DRAIN;
                ST_IDLE, ST_DRAIN: next_state = state;
                default:     next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        overrun     = 1'b0;
        timeout_err = 1'b0;
        load        = 1'b0;
        case (state)
            ST_SHIFT: timeout_err = rx_mode && !fsm_rst && !sh_en && (wdog == WD_MAX);
            ST_COMPLETE: begin
                load    = !pkt_valid || pkt_ready;
                overrun = pkt_valid && !pkt_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_sync <= '0;
        end else begin
            cmp_sync <= {cmp_sync[0], cmp_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr        <= '0;
            bit_cnt   <= '0;
            dly_cnt   <= '0;
            wdog      <= '0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
        end else begin
            if (clr_sr) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else if (sample_now) begin
                sr      <= sr_next;
                bit_cnt <= bit_cnt + CW'(1);
            end
            dly_cnt <= (state == ST_DELAY) ? dly_cnt + 4'd1 : 4'd1;
            // Watchdog runs from each accepted strobe through DELAY and SHIFT.
            if (strobe_ok || !(state == ST_DELAY || state == ST_SHIFT)) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + WW'(1);
            end
            if (load) begin
                pkt_data  <= sr;
                pkt_valid <= 1'b1;
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

`ifdef SH_RX_CRC_EN
    logic [7:0] crc, recv_crc;
    logic       crc_en;

    assign crc_en = sample_now && (bit_cnt < CW'(PACKET_BITS - 8));

    always_comb begin
        recv_crc = '0;
        for (int j = 0; j < 8; j++) begin
            recv_crc[7-j] = MSB_FIRST ? sr[7-j] : sr[PACKET_BITS-8+j];
        end
    end

    sh_rx_crc8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (next_state == ST_ARMED),
        .en     (crc_en),
        .bit_in (cmp_s),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_crc_ok <= 1'b0;
        end else if (load) begin
            pkt_crc_ok <= (crc == recv_crc);
        end
    end
`endif
endmodule

// File: tb/tb_sh_rx_deser.sv
// tb/tb_sh_rx_deser.sv - randomized scoreboard bench for sh_rx_deser
module tb_sh_rx_deser;
    localparam int PB = 64;
    localparam int SD = 2;
    localparam int TO = 15000;

    logic clk = 1'b0, rst = 1'b0, rx_mode = 1'b0, sh_en = 1'b0, fsm_rst = 1'b0;
    logic cmp_in = 1'b0, pkt_ready = 1'b0;
    logic [PB-1:0] pkt_data;
    logic pkt_valid, overrun, timeout_err;
`ifdef SH_RX_CRC_EN
    logic pkt_crc_ok;
`endif

    sh_rx_deser #(
        .PACKET_BITS(PB), .SAMPLE_DELAY(SD), .TIMEOUT_CYCLES(TO), .MSB_FIRST(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_mode     (rx_mode),
        .sh_en       (sh_en),
        .fsm_rst     (fsm_rst),
        .cmp_in      (cmp_in),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .overrun     (overrun),
        .timeout_err (timeout_err)
`ifdef SH_RX_CRC_EN
        ,
        .pkt_crc_ok  (pkt_crc_ok)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        crc_ok;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, last_strobe = 0;
    int          ovr_cnt = 0, exp_ovr = 0, to_cnt = 0, to_cyc = 0;
    bit          rand_mode = 1'b0;
    logic        ready_force = 1'b1;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [63:0] prev_data = '0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        pkt_ready = rand_mode ? ($urandom_range(3, 0) != 0) : ready_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC as polynomial long division of payload * x^8 by x^8+x^2+x+1.
    function automatic logic [7:0] crc8_div(input logic [55:0] p);
        logic [63:0] r;
        r = {p, 8'h00};
        for (int i = 63; i >= 8; i--) begin
            if (r[i]) r = r ^ (64'h107 << (i - 8));
        end
        return r[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (pkt_valid && !prev_valid) check("latency", 64'(cyc - last_strobe), 64'(SD + 2));
            if (pkt_valid && prev_valid && !prev_ready) check("data_stable", pkt_data, prev_data);
            if (pkt_valid && pkt_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_packet: got %h expected none", pkt_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pkt_data", pkt_data, e.data);
`ifdef SH_RX_CRC_EN
                    check("pkt_crc_ok", 64'(pkt_crc_ok), 64'(e.crc_ok));
`endif
                end
            end
            if (overrun) ovr_cnt++;
            if (timeout_err) begin
                to_cnt++;
                to_cyc = cyc;
            end
            prev_valid = pkt_valid;
            prev_ready = pkt_ready;
            prev_data  = pkt_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fsm_rst();
        fsm_rst = 1'b1;
        tick(1);
        fsm_rst = 1'b0;
        tick(2);
    endtask

    task automatic send_bit(input logic b, input int post);
        cmp_in = b;
        tick(3);
        sh_en = 1'b1;
        last_strobe = cyc;
        tick(1);
        sh_en = 1'b0;
        tick(post);
    endtask

    // Sends the top n bits of v in arrival order; a full packet is predicted as delivered or dropped.
    task automatic send_bits(input logic [63:0] v, input int n, input int lo, input int hi, input bit push);
        for (int i = 0; i < n; i++) begin
            if (push && i == PB - 1) begin
                exp_t e;
                e.data   = v;
                e.crc_ok = (crc8_div(v[63:8]) == v[7:0]);
                if (!rand_mode && !ready_force && sb.size() > 0) exp_ovr++;
                else sb.push_back(e);
            end
            send_bit(v[63-i], $urandom_range(hi, lo));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) tick(1);
    endtask

    initial begin
        logic [63:0] v, a;
        tick(3);
        check("reset_pkt_valid", 64'(pkt_valid), 64'd0);
        check("reset_pkt_data", pkt_data, 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_timeout_err", 64'(timeout_err), 64'd0);
        rst = 1'b1;
        rx_mode = 1'b1;
        tick(3);

        pulse_fsm_rst();
        send_bits(64'hA5A5_0F0F_1234_5678, PB, 96, 96, 1'b1);
        send_bit(1'b1, 96);
        check("basic_consumed", 64'(sb.size()), 64'd0);

        pulse_fsm_rst();
        send_bits({$urandom, $urandom}, 20, 3, 10, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_pkt_data", pkt_data, 64'd0);
        check("midrst_pkt_valid", 64'(pkt_valid), 64'd0);
        check("midrst_overrun", 64'(overrun), 64'd0);
        check("midrst_timeout_err", 64'(timeout_err), 64'd0);
        tick(2);
        rst = 1'b1;
        tick(2);
        pulse_fsm_rst();
        send_bits({$urandom, $urandom}, PB, 3, 10, 1'b1);

        pulse_fsm_rst();
        send_bits({$urandom, $urandom}, 30, 3, 10, 1'b0);
        pulse_fsm_rst();
        send_bits({$urandom, $urandom}, PB, 3, 10, 1'b1);
        wait_drain();

        ready_force = 1'b0;
        tick(3);
        a = {$urandom, $urandom};
        pulse_fsm_rst();
        send_bits(a, PB, 3, 8, 1'b1);
        pulse_fsm_rst();
        send_bits({$urandom, $urandom}, PB, 3, 8, 1'b1);
        tick(5);
        check("bp_pkt_valid", 64'(pkt_valid), 64'd1);
        check("bp_pkt_data_held", pkt_data, a);
        check("bp_overrun_count", 64'(ovr_cnt), 64'(exp_ovr));
        ready_force = 1'b1;
        wait_drain();
        tick(3);

        pulse_fsm_rst();
        send_bits({$urandom, $urandom}, 10, 3, 6, 1'b0);
        for (int i = 0; i < TO + 100 && to_cnt == 0; i++) tick(1);
        check("timeout_seen", 64'(to_cnt), 64'd1);
        check("timeout_delay", 64'(to_cyc - last_strobe), 64'(TO));
        check("timeout_pkt_valid", 64'(pkt_valid), 64'd0);
        send_bits({$urandom, $urandom}, PB, 3, 5, 1'b0);
        tick(10);

        rand_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            v = {$urandom, $urandom};
            if (k % 2 == 1) v[7:0] = crc8_div(v[63:8]);
            pulse_fsm_rst();
            send_bits(v, PB, 3, 12, 1'b1);
        end
        wait_drain();
        rand_mode = 1'b0;
        tick(3);

`ifdef SH_RX_CRC_EN
        pulse_fsm_rst();
        send_bits({56'h1, 8'h07}, PB, 3, 6, 1'b1);
        pulse_fsm_rst();
        send_bits({56'h1 ^ (56'h1 << 40), 8'h07}, PB, 3, 6, 1'b1);
`endif
        wait_drain();
        tick(10);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("overrun_total", 64'(ovr_cnt), 64'(exp_ovr));
        check("timeout_total", 64'(to_cnt), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sh_rx_deser.md
Name: sh_rx_deser

Overview:
Receive-path stage directly downstream of the sample-and-hold sync block. Consumes its sh_en strobes and fsm_rst pulses, samples the synchronized comparator output a fixed delay after each strobe, and assembles PACKET_BITS bits into a word. Completed words are handed to the packet consumer over a valid/ready handshake through a one-deep output register, so the next packet can shift in while the previous word waits.

Parameters:
PACKET_BITS, 64, bits per packet; shift width and output width
SAMPLE_DELAY, 2, clk cycles from sh_en to the sample point (range 0..15) to allow S/H settling
TIMEOUT_CYCLES, 15000, max clk cycles between sh_en strobes while shifting before abort (1.5 ms at 10 MHz)
MSB_FIRST, 1, 1: first received bit lands in pkt_data[PACKET_BITS-1]; 0: lands in bit 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx_mode  in  1  receive mode (same signal as RX); 0 forces IDLE
sh_en  in  1  single-cycle sample strobe from the sync block
fsm_rst  in  1  single-cycle re-arm pulse from the sync block (preamble edges, timeouts)
cmp_in  in  1  asynchronous comparator output
pkt_data  out  PACKET_BITS  completed packet word
pkt_valid  out  1  pkt_data holds an unconsumed packet
pkt_ready  in  1  consumer accepts pkt_data when pkt_valid && pkt_ready
overrun  out  1  1-cycle pulse: packet completed while the output register was full; packet dropped
timeout_err  out  1  1-cycle pulse: inter-strobe timeout while shifting

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, shift register and all counters cleared.
- cmp_in passes through a 2-flop synchronizer (cmp_s); all sampling uses cmp_s.
- States:
  - IDLE: waits. fsm_rst && rx_mode -> ARMED.
  - ARMED: shift register and bit_cnt cleared. sh_en -> DELAY. fsm_rst re-clears and stays in ARMED.
  - DELAY: dly_cnt counts up to SAMPLE_DELAY, then samples cmp_s. If SAMPLE_DELAY=0, cmp_s is sampled in the same cycle as sh_en.
    - Sampled bit is shifted in according to MSB_FIRST; bit_cnt increments.
    - bit_cnt reaches PACKET_BITS -> COMPLETE; otherwise -> SHIFT.
  - SHIFT: wdog counts clk cycles.
    - sh_en -> DELAY and wdog clears.
    - wdog == TIMEOUT_CYCLES-1 -> timeout_err pulse, go to IDLE.
  - COMPLETE (1 cycle): performs the transfer below, then goes to DRAIN.
    - If !pkt_valid, or pkt_valid && pkt_ready in this cycle: pkt_data <= shift register and pkt_valid <= 1.
    - Otherwise: overrun pulse; the new packet is discarded.
  - DRAIN: extra sh_en strobes are ignored (the sync block emits PACKET_SIZE+1 strobes). fsm_rst -> ARMED.
- fsm_rst takes priority over sh_en in every state except COMPLETE. A fsm_rst seen in COMPLETE is honored on the next cycle.
- An sh_en arriving during DELAY is ignored; it is not queued.
- rx_mode low in any state -> IDLE next cycle. The shift register is cleared; pkt_data and pkt_valid are retained.
- Handshake:
  - pkt_valid clears on the cycle after pkt_valid && pkt_ready.
  - pkt_data is stable while pkt_valid is 1.
  - pkt_ready is ignored while pkt_valid is 0.
- Latency: last sh_en -> pkt_valid high is SAMPLE_DELAY+2 cycles when the output register is free.
- bit_cnt width is $clog2(PACKET_BITS+1). It never exceeds PACKET_BITS; there is no wrap.

Optional Feature:
Macro SH_RX_CRC_EN.
- Defined: adds output pkt_crc_ok (1 bit), valid and stable while pkt_valid.
  - CRC-8 (poly 0x07, init 0x00) is computed serially over the first PACKET_BITS-8 received bits, in arrival order.
  - The result is compared with the last 8 received bits (first received = CRC MSB).
  - The CRC register clears in ARMED and updates in the sample cycle.
- Undefined: no pkt_crc_ok port and no CRC logic.

Decomposition:
- Shared package sh_rx_pkg holds:
  - state encoding localparams (IDLE, ARMED, DELAY, SHIFT, COMPLETE, DRAIN);
  - CRC8_POLY = 8'h07;
  - default PACKET_BITS = 64 and TIMEOUT_CYCLES = 15000.
- One sub-module, sh_rx_crc8: serial CRC-8 with clear/enable/bit inputs. Instantiated only under SH_RX_CRC_EN.

Test Plan:
- Reset mid-packet: assert rst after 20 bits -> all outputs 0 immediately; a fresh fsm_rst plus 64 strobes yields a normal packet.
- Basic packet: fsm_rst, then 65 strobes 100 cycles apart, cmp_in = 0xA5A5_0F0F_1234_5678 MSB first; pkt_ready=1 -> pkt_valid for 1 cycle with that exact value, SAMPLE_DELAY+2 cycles after the 64th strobe; the 65th strobe is ignored.
- Backpressure/overrun: pkt_ready=0 and two packets sent back-to-back -> first value held, one overrun pulse at the second COMPLETE, pkt_data unchanged.
- Re-arm: fsm_rst after 30 bits, then 64 new bits -> pkt_data equals only the new 64 bits.
- Timeout: 10 strobes, then silence -> timeout_err pulses exactly TIMEOUT_CYCLES cycles after the 10th strobe; state IDLE; pkt_valid stays 0.
- CRC (SH_RX_CRC_EN defined): 56-bit payload 0x00_0000_0000_0001 with correct CRC byte 0x07 -> pkt_crc_ok=1; flip one payload bit -> pkt_crc_ok=0.
